// File: rtl/sweep_pkg.sv
// Shared types and defaults for the truth-table sweeper.
package sweep_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HOLD  = 3'd1,
    S_SAMP0 = 3'd2,
    S_SAMP1 = 3'd3,
    S_DONE  = 3'd4
  } sweep_state_t;

  localparam int unsigned DEFAULT_N_IN   = 4;
  localparam int unsigned DEFAULT_SETTLE = 2;

  function automatic int unsigned tt_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// 8-bit loadable down-counter that paces the settle interval of each vector.
module sweep_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec,
  output logic [7:0] o_value,
  output logic       o_zero_c
);

  logic [7:0] r_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= 8'd0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (i_dec && (r_value != 8'd0)) begin
      r_value <= r_value - 8'd1;
    end
  end

  assign o_value  = r_value;
  assign o_zero_c = (r_value == 8'd0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input vector of a gate netlist, double-samples its output and
// packs the results into a truth-table word (the function ID).
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int unsigned N_IN   = DEFAULT_N_IN,
  parameter int unsigned SETTLE = DEFAULT_SETTLE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic [N_IN-1:0]           dut_in,
  input  logic                      dut_out,
  output logic [tt_width(N_IN)-1:0] tt,
  output logic                      tt_valid,
  input  logic                      tt_ready,
  output logic                      unstable,
  output logic [N_IN-1:0]           unstable_idx
);

  localparam int unsigned TT_W     = tt_width(N_IN);
  localparam logic        HAS_HOLD = (SETTLE != 0);
  // The timer holds SETTLE-1 on entry so HOLD lasts exactly SETTLE cycles.
  localparam logic [7:0]  LOAD_VAL = HAS_HOLD ? 8'(SETTLE - 1) : 8'd0;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TT_W - 1);

  sweep_state_t       r_state, w_state_nxt;
  logic [N_IN-1:0]    r_idx, w_idx_nxt;
  logic [TT_W-1:0]    r_tt, w_tt_nxt;
  logic               r_tt_valid, w_tt_valid_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_unstable, w_unstable_nxt;
  logic [N_IN-1:0]    r_unstable_idx, w_unstable_idx_nxt;
  logic               r_s0, w_s0_nxt;
  logic               w_load;
  logic               w_dec;
  logic [7:0]         w_cnt_value;
  logic               w_cnt_zero;

  sweep_settle_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_dec),
    .o_value    (w_cnt_value),
    .o_zero_c   (w_cnt_zero)
  );

  assign w_dec = (r_state == S_HOLD) && (w_cnt_value != 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_tt           <= '0;
      r_tt_valid     <= 1'b0;
      r_busy         <= 1'b0;
      r_unstable     <= 1'b0;
      r_unstable_idx <= '0;
      r_s0           <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_idx          <= w_idx_nxt;
      r_tt           <= w_tt_nxt;
      r_tt_valid     <= w_tt_valid_nxt;
      r_busy         <= w_busy_nxt;
      r_unstable     <= w_unstable_nxt;
      r_unstable_idx <= w_unstable_idx_nxt;
      r_s0           <= w_s0_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_idx_nxt          = r_idx;
    w_tt_nxt           = r_tt;
    w_tt_valid_nxt     = r_tt_valid;
    w_busy_nxt         = r_busy;
    w_unstable_nxt     = r_unstable;
    w_unstable_idx_nxt = r_unstable_idx;
    w_s0_nxt           = r_s0;
    w_load             = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_busy_nxt         = 1'b1;
          w_idx_nxt          = '0;
          w_tt_nxt           = '0;
          w_unstable_nxt     = 1'b0;
          w_unstable_idx_nxt = '0;
          w_load             = HAS_HOLD;
          w_state_nxt        = HAS_HOLD ? S_HOLD : S_SAMP0;
        end
      end
      S_HOLD: begin
        if (w_cnt_zero) w_state_nxt = S_SAMP0;
      end
      S_SAMP0: begin
        w_s0_nxt    = dut_out;
        w_state_nxt = S_SAMP1;
      end
      S_SAMP1: begin
        w_tt_nxt[r_idx] = dut_out;
        if ((dut_out != r_s0) && !r_unstable) begin
          w_unstable_nxt     = 1'b1;
          w_unstable_idx_nxt = r_idx;
        end
        // End of sweep is found by compare so idx never needs an extra bit.
        if (r_idx == LAST_IDX) begin
          w_tt_valid_nxt = 1'b1;
          w_state_nxt    = S_DONE;
        end else begin
          w_idx_nxt   = r_idx + N_IN'(1);
          w_load      = HAS_HOLD;
          w_state_nxt = HAS_HOLD ? S_HOLD : S_SAMP0;
        end
      end
      S_DONE: begin
        if (tt_ready) begin
          w_tt_valid_nxt = 1'b0;
          w_busy_nxt     = 1'b0;
          w_idx_nxt      = '0;
          w_state_nxt    = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy         = r_busy;
  assign dut_in       = r_idx;
  assign tt           = r_tt;
  assign tt_valid     = r_tt_valid;
  assign unstable     = r_unstable;
  assign unstable_idx = r_unstable_idx;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: default build plus a 2-input, zero-settle build.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start = 1'b0;
  logic        busy;
  logic [3:0]  dut_in;
  logic        dut_out;
  logic [15:0] tt;
  logic        tt_valid;
  logic        tt_ready = 1'b0;
  logic        unstable;
  logic [3:0]  unstable_idx;
  int          mode = 0;
  logic        inv = 1'b0;

  logic        start2 = 1'b0;
  logic        busy2;
  logic [1:0]  dut_in2;
  logic        dut_out2;
  logic [3:0]  tt2;
  logic        tt_valid2;
  logic        tt_ready2 = 1'b0;
  logic        unstable2;
  logic [1:0]  unstable_idx2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign dut_out  = ((mode == 0) ? (&dut_in) : (^dut_in)) ^ inv;
  assign dut_out2 = &dut_in2;

  truth_table_sweeper u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .dut_in(dut_in),
    .dut_out(dut_out), .tt(tt), .tt_valid(tt_valid), .tt_ready(tt_ready),
    .unstable(unstable), .unstable_idx(unstable_idx)
  );

  truth_table_sweeper #(.N_IN(2), .SETTLE(0)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .dut_in(dut_in2),
    .dut_out(dut_out2), .tt(tt2), .tt_valid(tt_valid2), .tt_ready(tt_ready2),
    .unstable(unstable2), .unstable_idx(unstable_idx2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic accept();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges after the accept edge until tt_valid; optional SAMP1 glitches on vectors 5 and 9.
  task automatic wait_valid(output int edges, output bit busy_ok, input bit glitch);
    edges   = 0;
    busy_ok = 1'b1;
    while (!tt_valid && edges < 500) begin
      tick();
      edges++;
      if (!busy) busy_ok = 1'b0;
      inv = glitch && (edges == 23 || edges == 39);
    end
    inv = 1'b0;
  endtask

  initial begin
    int  edges;
    bit  ok;
    logic [15:0] tt_snap;

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dut_in", 32'(dut_in), 32'd0);
    check("rst_tt", 32'(tt), 32'd0);
    check("rst_tt_valid", 32'(tt_valid), 32'd0);
    check("rst_unstable", 32'(unstable), 32'd0);
    check("rst_unstable_idx", 32'(unstable_idx), 32'd0);
    check("rst2_busy", 32'(busy2), 32'd0);
    check("rst2_tt", 32'(tt2), 32'd0);

    // AND loopback with default parameters
    mode = 0;
    accept();
    check("t1_busy_after_accept", 32'(busy), 32'd1);
    wait_valid(edges, ok, 1'b0);
    check("t1_latency", 32'(edges), 32'd64);
    check("t1_busy_held", 32'(ok), 32'd1);
    check("t1_tt", 32'(tt), 32'h8000);
    check("t1_unstable", 32'(unstable), 32'd0);
    check("t1_unstable_idx", 32'(unstable_idx), 32'd0);
    tt_ready = 1'b1;
    tick();
    tt_ready = 1'b0;
    check("t1_hs_valid", 32'(tt_valid), 32'd0);
    check("t1_hs_busy", 32'(busy), 32'd0);
    check("t1_tt_retained", 32'(tt), 32'h8000);

    // Parity loopback with tt_ready tied high
    mode = 1;
    tt_ready = 1'b1;
    accept();
    wait_valid(edges, ok, 1'b0);
    check("t2_latency", 32'(edges), 32'd64);
    check("t2_tt", 32'(tt), 32'h6996);
    check("t2_busy_at_valid", 32'(busy), 32'd1);
    tick();
    check("t2_valid_fall", 32'(tt_valid), 32'd0);
    check("t2_busy_fall", 32'(busy), 32'd0);
    check("t2_dut_in_zero", 32'(dut_in), 32'd0);
    tt_ready = 1'b0;

    // Parity with SAMP1-only glitches on vectors 5 and 9
    accept();
    wait_valid(edges, ok, 1'b1);
    check("t3_tt", 32'(tt), 32'h6bb6);
    check("t3_unstable", 32'(unstable), 32'd1);
    check("t3_unstable_idx", 32'(unstable_idx), 32'd5);
    tt_ready = 1'b1;
    tick();
    tt_ready = 1'b0;

    // Reset during HOLD of vector 7, then a fresh sweep
    accept();
    for (int e = 0; e < 29; e++) tick();
    check("t4_pre_rst_dut_in", 32'(dut_in), 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_dut_in", 32'(dut_in), 32'd0);
    check("t4_tt", 32'(tt), 32'd0);
    check("t4_tt_valid", 32'(tt_valid), 32'd0);
    accept();
    wait_valid(edges, ok, 1'b0);
    check("t4_latency", 32'(edges), 32'd64);
    check("t4_tt", 32'(tt), 32'h6996);

    // Result held under back-pressure while start is pulsed
    tt_snap = tt;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start = (i % 2 == 0);
      tick();
      if (tt !== 16'h6996 || tt_valid !== 1'b1 || busy !== 1'b1 || dut_in !== 4'd15) ok = 1'b0;
    end
    start = 1'b0;
    check("t5_held_stable", 32'(ok), 32'd1);
    check("t5_tt_snapshot", 32'(tt_snap), 32'h6996);
    tt_ready = 1'b1;
    tick();
    tt_ready = 1'b0;
    check("t5_hs_valid", 32'(tt_valid), 32'd0);
    check("t5_hs_busy", 32'(busy), 32'd0);
    check("t5_hs_dut_in", 32'(dut_in), 32'd0);
    tick();
    check("t5_no_restart", 32'(busy), 32'd0);

    // Two inputs, zero settle: each vector held two cycles
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    ok = 1'b1;
    for (int e = 1; e < 8; e++) begin
      tick();
      if (dut_in2 !== 2'(e / 2) || tt_valid2 !== 1'b0 || busy2 !== 1'b1) ok = 1'b0;
    end
    check("t6_vector_hold", 32'(ok), 32'd1);
    tick();
    check("t6_valid_at_8", 32'(tt_valid2), 32'd1);
    check("t6_tt", 32'(tt2), 32'h8);
    check("t6_unstable", 32'(unstable2), 32'd0);
    tt_ready2 = 1'b1;
    tick();
    tt_ready2 = 1'b0;
    check("t6_hs_valid", 32'(tt_valid2), 32'd0);
    check("t6_hs_dut_in", 32'(dut_in2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
